// File: rtl/fifo_frame_reader.sv
// Frame-gated read sequencer for a synchronous FIFO, with a 4-entry skid buffer feeding a valid/ready stream.
// Define FIFO_RD_OREG_EN when the FIFO output register is enabled (read latency 2, rd_oce driven).
module fifo_frame_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 11,
    parameter int FRAME_LEN   = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   fifo_rd_en,
    output logic                   fifo_rd_oce,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   frame_done
);

`ifdef FIFO_RD_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]          FL     = CW'(FRAME_LEN);
    localparam logic [CW-1:0]          FL_M1  = CW'(FRAME_LEN - 1);
    localparam logic [LEVEL_WIDTH-1:0] FL_LVL = LEVEL_WIDTH'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, WAIT_LVL, BURST, DRAIN} state_t;

    state_t                  state_reg;
    logic                    rd_en_reg;
    logic [LAT-1:0]          rd_pipe_reg;   // bit i set: read issued i+1 cycles ago
    logic [CW-1:0]           issued_reg;
    logic [CW-1:0]           beat_reg;
    logic [DATA_WIDTH-1:0]   skid_mem [4];
    logic [1:0]              head_reg;
    logic [1:0]              tail_reg;
    logic [2:0]              buf_cnt_reg;
    logic                    frame_done_reg;

    logic       push;
    logic       pop;
    logic       last_hs;
    logic       issue_next;
    logic [1:0] inflight;
    logic [3:0] credit;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {1'b0, rd_pipe_reg[i]};
        end
    end

    assign push       = rd_pipe_reg[LAT-1];
    assign m_valid    = (buf_cnt_reg != 3'd0);
    assign m_data     = m_valid ? skid_mem[head_reg] : '0;
    assign m_last     = m_valid && (beat_reg == FL_M1);
    assign pop        = m_valid && m_ready;
    assign last_hs    = pop && m_last;
    // Every read committed so far must still fit in the buffer even if nothing pops.
    assign credit     = {1'b0, buf_cnt_reg} + {2'b00, inflight} + {3'b000, rd_en_reg};
    assign issue_next = (state_reg == BURST) && (issued_reg < FL) && !fifo_rd_empty && (credit < 4'd4);

    assign fifo_rd_en = rd_en_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_done_reg;

`ifdef FIFO_RD_OREG_EN
    assign fifo_rd_oce = rd_pipe_reg[0];
`else
    assign fifo_rd_oce = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            skid_mem[tail_reg] <= fifo_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rd_en_reg      <= 1'b0;
            rd_pipe_reg    <= '0;
            issued_reg     <= '0;
            beat_reg       <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            buf_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            rd_en_reg      <= issue_next;
            rd_pipe_reg    <= LAT'({rd_pipe_reg, rd_en_reg});
            frame_done_reg <= last_hs;

            if (push) begin
                tail_reg <= tail_reg + 2'd1;
            end
            if (pop) begin
                head_reg <= head_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   buf_cnt_reg <= buf_cnt_reg + 3'd1;
                2'b01:   buf_cnt_reg <= buf_cnt_reg - 3'd1;
                default: buf_cnt_reg <= buf_cnt_reg;
            endcase

            if (last_hs) begin
                beat_reg <= '0;
            end else if (pop) begin
                beat_reg <= beat_reg + 1'b1;
            end

            if (issue_next) begin
                issued_reg <= issued_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= WAIT_LVL;
                    end
                end
                WAIT_LVL: begin
                    // A disabled block never starts a new frame, even if data is waiting.
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else if (fifo_rd_water_level >= FL_LVL) begin
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (issued_reg == FL) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        issued_reg <= '0;
                        state_reg  <= enable ? WAIT_LVL : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with FRAME_LEN=16 and a behavioural synchronous FIFO model.
module tb_fifo_frame_reader;
    localparam int DW = 32;
    localparam int LW = 11;
    localparam int FLEN = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_rd_en;
    logic          fifo_rd_oce;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_water_level;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          frame_done;

    fifo_frame_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_oce(fifo_rd_oce), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // FIFO model: word k holds A500_0000 + k; force_empty emulates a lagging empty flag.
    logic [DW-1:0] mem [256];
    int            wptr = 0;
    int            rptr = 0;
    logic          force_empty = 1'b0;
    logic [DW-1:0] rd_q = '0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_q <= mem[rptr % 256];
            rptr <= rptr + 1;
        end
    end
`ifdef FIFO_RD_OREG_EN
    logic [DW-1:0] rd_q2 = '0;
    always @(posedge clk) if (fifo_rd_oce) rd_q2 <= rd_q;
    assign fifo_rd_data = rd_q2;
`else
    assign fifo_rd_data = rd_q;
`endif
    assign fifo_rd_empty       = (wptr == rptr) || force_empty;
    assign fifo_rd_water_level = LW'(wptr - rptr);

    // Observation monitor, sampled on the falling edge.
    logic [DW-1:0] beat_q [$];
    logic          last_q [$];
    int            bcyc_q [$];
    int            cyc = 0;
    int            rd_cnt = 0;
    int            fd_cnt = 0;
    int            empty_err = 0;
    int            stab_err = 0;
    int            max_out = 0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;

    always @(negedge clk) begin
        int outst;
        cyc = cyc + 1;
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (wptr == rptr) empty_err = empty_err + 1;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (m_valid && m_ready) begin
            beat_q.push_back(m_data);
            last_q.push_back(m_last);
            bcyc_q.push_back(cyc);
        end
        if (rst_n && hold_pend && (!m_valid || m_data !== hold_data)) stab_err = stab_err + 1;
        hold_pend = rst_n && m_valid && !m_ready;
        hold_data = m_data;
        outst = int'(dut.buf_cnt_reg) + int'(dut.inflight);
        if (outst > max_out) max_out = outst;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr % 256] = 32'hA500_0000 + 32'(wptr);
            wptr = wptr + 1;
        end
    endtask

    task automatic wait_frame(input int fd_target, input string tag);
        int k = 0;
        while (fd_cnt < fd_target && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 64'(fd_cnt >= fd_target), 64'd1);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k = 0;
        while (beat_q.size() < n && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 64'(beat_q.size() >= n), 64'd1);
    endtask

    // Beats b..b+15 must be FIFO words w..w+15 in order, m_last on the 16th only.
    task automatic check_frame(input int b, input int w, input string tag);
        check({tag, "_count"}, 64'(beat_q.size() >= b + FLEN), 64'd1);
        if (beat_q.size() >= b + FLEN) begin
            for (int i = 0; i < FLEN; i++) begin
                check($sformatf("%s_data%0d", tag, i), 64'(beat_q[b + i]), 64'(32'hA500_0000 + 32'(w + i)));
                check($sformatf("%s_last%0d", tag, i), 64'(last_q[b + i]), 64'(i == FLEN - 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bi;
        int wi;
        int rd_base;
        int fd_base;
        logic [1:0] rpat [4];
        rpat[0] = 2'd1; rpat[1] = 2'd0; rpat[2] = 2'd0; rpat[3] = 2'd1;

        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b1;
        tick(3);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_rd_oce", 64'(fifo_rd_oce), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Level gating: 15 words must not start a burst.
        bi = beat_q.size(); wi = wptr; rd_base = rd_cnt; fd_base = fd_cnt;
        write_words(15);
        enable = 1'b1;
        tick(20);
        check("lvl_no_rd", 64'(rd_cnt - rd_base), 64'd0);
        check("lvl_busy", 64'(busy), 64'd1);
        write_words(1);
        wait_frame(fd_base + 1, "lvl_done");
        tick(3);
        check("lvl_rd_pulses", 64'(rd_cnt - rd_base), 64'd16);
        check("lvl_one_done", 64'(fd_cnt - fd_base), 64'd1);
        check_frame(bi, wi, "lvl");

        // Backpressure: m_ready cycles 1,0,0,1.
        bi = beat_q.size(); wi = wptr; rd_base = rd_cnt; fd_base = fd_cnt;
        write_words(16);
        for (int k = 0; k < 300 && fd_cnt == fd_base; k++) begin
            m_ready = rpat[k % 4][0];
            tick(1);
        end
        m_ready = 1'b1;
        check("bp_done", 64'(fd_cnt - fd_base), 64'd1);
        check("bp_rd_pulses", 64'(rd_cnt - rd_base), 64'd16);
        check("bp_stable", 64'(stab_err), 64'd0);
        check("bp_credit", 64'(max_out <= 4), 64'd1);
        check("bp_no_empty_rd", 64'(empty_err), 64'd0);
        check_frame(bi, wi, "bp");

        // Throughput: two back-to-back frames with m_ready held high.
        bi = beat_q.size(); wi = wptr; fd_base = fd_cnt;
        write_words(32);
        wait_frame(fd_base + 2, "tp_done");
        check_frame(bi, wi, "tp_f0");
        check_frame(bi + FLEN, wi + FLEN, "tp_f1");
        if (bcyc_q.size() >= bi + 2 * FLEN) begin
            check("tp_f0_contig", 64'(bcyc_q[bi + FLEN - 1] - bcyc_q[bi]), 64'(FLEN - 1));
            check("tp_f1_contig", 64'(bcyc_q[bi + 2 * FLEN - 1] - bcyc_q[bi + FLEN]), 64'(FLEN - 1));
        end

        // Enable dropped after 5 accepted beats: frame still completes, then IDLE.
        bi = beat_q.size(); wi = wptr; rd_base = rd_cnt; fd_base = fd_cnt;
        write_words(16);
        wait_beats(bi + 5, "en_5beats");
        enable = 1'b0;
        wait_frame(fd_base + 1, "en_done");
        tick(2);
        check("en_idle_busy", 64'(busy), 64'd0);
        check("en_rd_pulses", 64'(rd_cnt - rd_base), 64'd16);
        check_frame(bi, wi, "en");

        // Empty stall: empty forced for 3 cycles mid-burst.
        enable = 1'b1;
        bi = beat_q.size(); wi = wptr; rd_base = rd_cnt; fd_base = fd_cnt;
        write_words(16);
        for (int k = 0; k < 100 && (rd_cnt - rd_base) < 4; k++) tick(1);
        check("es_started", 64'((rd_cnt - rd_base) >= 4), 64'd1);
        force_empty = 1'b1;
        tick(1);
        check("es_stall1", 64'(fifo_rd_en), 64'd0);
        tick(1);
        check("es_stall2", 64'(fifo_rd_en), 64'd0);
        tick(1);
        check("es_stall3", 64'(fifo_rd_en), 64'd0);
        force_empty = 1'b0;
        wait_frame(fd_base + 1, "es_done");
        tick(2);
        check("es_rd_pulses", 64'(rd_cnt - rd_base), 64'd16);
        check_frame(bi, wi, "es");

        // Reset mid-burst after 7 beats; the following frame restarts at beat 0.
        bi = beat_q.size();
        write_words(16);
        wait_beats(bi + 7, "rb_7beats");
        rst_n = 1'b0;
        tick(1);
        check("rb_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rb_m_valid", 64'(m_valid), 64'd0);
        check("rb_m_data", 64'(m_data), 64'd0);
        check("rb_m_last", 64'(m_last), 64'd0);
        check("rb_busy", 64'(busy), 64'd0);
        check("rb_frame_done", 64'(frame_done), 64'd0);
        rst_n = 1'b1;
        tick(1);
        bi = beat_q.size(); wi = rptr; fd_base = fd_cnt;
        write_words(16);
        wait_frame(fd_base + 1, "rb_done");
        check_frame(bi, wi, "rb");
        check("rb_no_empty_rd", 64'(empty_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
